mips_v0_lockstep_checker: RTL and testbench

Downstream consumer of the three MIPS cores' debug outputs in the unified bench: it watches `reg_v0` from the single-cycle, multicycle and pipelined cores and checks that they produce the same sequence of values. Each core changes `$v0` at a different cycle, so the checker queues each lane's value-change events in a per-lane FIFO. When all three lanes hold an event, it compares the oldest entries. It reports a running match count, a sticky mismatch flag with captured values, and a sticky overflow flag.

---
 rtl/mips_v0_lockstep_checker.sv | 115 +++++++++++
 tb/tb_mips_v0_lockstep_checker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_v0_lockstep_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_v0_lockstep_checker
// Queues $v0 value changes from three MIPS cores and compares them in order.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mips_v0_lockstep_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] v0_sc,
  input  logic [WIDTH-1:0] v0_mc,
  input  logic [WIDTH-1:0] v0_pl,
  output logic [CNT_W-1:0] match_count,
  output logic             mismatch,
  output logic [2:0]       bad_lanes,
  output logic [WIDTH-1:0] bad_sc,
  output logic [WIDTH-1:0] bad_mc,
  output logic [WIDTH-1:0] bad_pl,
  output logic             overflow,
  output logic             idle
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] w_lane_in [3];
  logic [WIDTH-1:0] w_head    [3];
  logic [2:0]       w_empty;
  logic [2:0]       w_full;
  logic [2:0]       w_change;
  logic [2:0]       w_push;
  logic [2:0]       w_drop;
  logic             w_valid;
  logic             w_all_eq;
  logic [2:0]       w_lanes;

  assign w_lane_in[0] = v0_sc;
  assign w_lane_in[1] = v0_mc;
  assign w_lane_in[2] = v0_pl;

  assign w_valid = (w_empty == 3'b000);

  for (genvar i = 0; i < 3; i++) begin : g_lane
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    assign w_empty[i]  = (r_wptr == r_rptr);
    assign w_full[i]   = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_change[i] = (w_lane_in[i] != r_prev);
    // A full FIFO still accepts a push when its head pops on the same edge.
    assign w_push[i]   = w_change[i] & (~w_full[i] | w_valid);
    assign w_drop[i]   = w_change[i] & w_full[i] & ~w_valid;
    assign w_head[i]   = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_prev <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_change[i]) r_prev <= w_lane_in[i];
        if (w_push[i])   r_wptr <= r_wptr + 1'b1;
        if (w_valid)     r_rptr <= r_rptr + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst && w_push[i]) r_mem[r_wptr[AW-1:0]] <= w_lane_in[i];
    end
  end

  // Lane mask against the 2-of-3 majority; no majority flags every lane.
  always_comb begin
    w_all_eq = (w_head[0] == w_head[1]) && (w_head[1] == w_head[2]);
    w_lanes  = 3'b111;
    if (w_head[0] == w_head[1])      w_lanes = 3'b100;
    else if (w_head[0] == w_head[2]) w_lanes = 3'b010;
    else if (w_head[1] == w_head[2]) w_lanes = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
      mismatch    <= 1'b0;
      bad_lanes   <= 3'b000;
      bad_sc      <= '0;
      bad_mc      <= '0;
      bad_pl      <= '0;
      overflow    <= 1'b0;
    end else begin
      if (w_valid) begin
        if (w_all_eq) begin
          match_count <= match_count + 1'b1;
        end else if (!mismatch) begin
          mismatch  <= 1'b1;
          bad_lanes <= w_lanes;
          bad_sc    <= w_head[0];
          bad_mc    <= w_head[1];
          bad_pl    <= w_head[2];
        end
      end
      if (|w_drop) overflow <= 1'b1;
    end
  end

  assign idle = &w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mips_v0_lockstep_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_v0_lockstep_checker
// Table vectors, directed corner sequences and a randomized queue-model check.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mips_v0_lockstep_checker;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] v0_sc = '0;
  logic [WIDTH-1:0] v0_mc = '0;
  logic [WIDTH-1:0] v0_pl = '0;
  logic [CNT_W-1:0] match_count;
  logic             mismatch;
  logic [2:0]       bad_lanes;
  logic [WIDTH-1:0] bad_sc;
  logic [WIDTH-1:0] bad_mc;
  logic [WIDTH-1:0] bad_pl;
  logic             overflow;
  logic             idle;

  int checks   = 0;
  int failures = 0;

  mips_v0_lockstep_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .v0_sc(v0_sc), .v0_mc(v0_mc), .v0_pl(v0_pl),
    .match_count(match_count), .mismatch(mismatch), .bad_lanes(bad_lanes),
    .bad_sc(bad_sc), .bad_mc(bad_mc), .bad_pl(bad_pl),
    .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane, evaluated once per rising edge.
  logic [WIDTH-1:0] q0[$], q1[$], q2[$];
  logic [WIDTH-1:0] m_prev [3];
  logic [CNT_W-1:0] m_cnt;
  logic             m_mis, m_ovf;
  logic [2:0]       m_lanes;
  logic [WIDTH-1:0] m_bad [3];

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic model_step(input bit r, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] inv [3];
    logic [WIDTH-1:0] h [3];
    bit pop;
    inv[0] = a; inv[1] = b; inv[2] = c;
    if (r) begin
      q0.delete(); q1.delete(); q2.delete();
      for (int i = 0; i < 3; i++) begin m_prev[i] = '0; m_bad[i] = '0; end
      m_cnt = '0; m_mis = 0; m_ovf = 0; m_lanes = 3'b000;
      return;
    end
    pop = (q0.size() > 0) && (q1.size() > 0) && (q2.size() > 0);
    if (pop) begin
      h[0] = q0[0]; h[1] = q1[0]; h[2] = q2[0];
      if (h[0] == h[1] && h[1] == h[2]) m_cnt = m_cnt + 1'b1;
      else if (!m_mis) begin
        m_mis = 1;
        for (int i = 0; i < 3; i++) m_bad[i] = h[i];
        if (h[0] == h[1])      m_lanes = 3'b100;
        else if (h[0] == h[2]) m_lanes = 3'b010;
        else if (h[1] == h[2]) m_lanes = 3'b001;
        else                   m_lanes = 3'b111;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (inv[i] != m_prev[i]) begin
        m_prev[i] = inv[i];
        if (qsize(i) < DEPTH || pop) begin
          case (i)
            0:       q0.push_back(inv[i]);
            1:       q1.push_back(inv[i]);
            default: q2.push_back(inv[i]);
          endcase
        end else m_ovf = 1;
      end
    end
    if (pop) begin
      void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then compare every output with the model.
  task automatic cyc(input bit r, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    logic m_idle;
    rst = r; v0_sc = a; v0_mc = b; v0_pl = c;
    @(posedge clk);
    model_step(r, a, b, c);
    #1;
    m_idle = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0);
    checks++;
    if ({match_count, mismatch, bad_lanes, overflow, idle} !==
          {m_cnt, m_mis, m_lanes, m_ovf, m_idle} ||
        bad_sc !== m_bad[0] || bad_mc !== m_bad[1] || bad_pl !== m_bad[2]) begin
      failures++;
      $display("FAIL model @%0t: got cnt=%0d mis=%0b lanes=%b ovf=%0b idle=%0b bad=%0h/%0h/%0h expected cnt=%0d mis=%0b lanes=%b ovf=%0b idle=%0b bad=%0h/%0h/%0h",
               $time, match_count, mismatch, bad_lanes, overflow, idle, bad_sc, bad_mc, bad_pl,
               m_cnt, m_mis, m_lanes, m_ovf, m_idle, m_bad[0], m_bad[1], m_bad[2]);
    end
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    bit               rst;
    logic [WIDTH-1:0] sc, mc, pl;
    logic [CNT_W-1:0] exp_cnt;
    bit               exp_mis;
    bit               exp_idle;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input bit r, input int a, input int b, input int c,
                              input int cnt, input bit mis, input bit idl);
    vec_t v;
    v.rst = r; v.sc = a; v.mc = b; v.pl = c;
    v.exp_cnt = cnt[CNT_W-1:0]; v.exp_mis = mis; v.exp_idle = idl;
    return v;
  endfunction

  initial begin
    int idx [3];
    logic [WIDTH-1:0] cur [3];

    @(posedge clk); #1;

    // Reset held with random inputs: every output cleared.
    cyc(1, $urandom, $urandom, $urandom);
    cyc(1, $urandom, $urandom, $urandom);
    chk("rst_outputs", {match_count, mismatch, bad_lanes, overflow}, 0);
    chk("rst_bad", {bad_sc, bad_mc}, 0);
    chk("rst_bad_pl", bad_pl, 0);
    chk("rst_idle", idle, 1);

    // Skewed match: sc at edge 3, mc at edge 7, pl at edge 12, compare at 13.
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[1] = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 1);
    for (int i = 3; i < 7; i++)   tbl[i] = mk(0, 5, 0, 0, 0, 0, 0);
    for (int i = 7; i < 12; i++)  tbl[i] = mk(0, 5, 5, 0, 0, 0, 0);
    tbl[12] = mk(0, 5, 5, 5, 0, 0, 0);
    tbl[13] = mk(0, 5, 5, 5, 1, 0, 1);
    tbl[14] = mk(0, 5, 5, 5, 1, 0, 1);
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rst, tbl[i].sc, tbl[i].mc, tbl[i].pl);
      chk($sformatf("tbl%0d_cnt", i), match_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_mis", i), mismatch, tbl[i].exp_mis);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].exp_idle);
    end

    // Sequence 1..4 with different step rates per lane.
    do_reset();
    for (int t = 0; t < 30; t++) begin
      int a, b, c;
      a = (t + 1 > 4) ? 4 : t + 1;
      b = (t / 4 + 1 > 4) ? 4 : t / 4 + 1;
      c = (t < 6) ? 0 : (((t - 6) / 2 + 1 > 4) ? 4 : (t - 6) / 2 + 1);
      cyc(0, a, b, c);
    end
    chk("seq_cnt", match_count, 4);
    chk("seq_mis", mismatch, 0);
    chk("seq_ovf", overflow, 0);

    // Single-lane mismatch then a match, then a later mismatch.
    do_reset();
    cyc(0, 7, 9, 7);
    cyc(0, 10, 10, 10);
    cyc(0, 10, 10, 10);
    cyc(0, 10, 10, 10);
    chk("mis1_flag", mismatch, 1);
    chk("mis1_lanes", bad_lanes, 3'b010);
    chk("mis1_vals", {bad_sc, bad_mc}, {32'd7, 32'd9});
    chk("mis1_pl", bad_pl, 7);
    chk("mis1_cnt", match_count, 1);
    cyc(0, 11, 12, 13);
    cyc(0, 11, 12, 13);
    cyc(0, 11, 12, 13);
    chk("mis2_vals", {bad_sc, bad_mc}, {32'd7, 32'd9});
    chk("mis2_lanes", bad_lanes, 3'b010);
    chk("mis2_cnt", match_count, 1);
    chk("mis2_idle", idle, 1);

    // Three-way mismatch.
    do_reset();
    cyc(0, 1, 2, 3);
    cyc(0, 1, 2, 3);
    chk("mis3_lanes", bad_lanes, 3'b111);
    chk("mis3_vals", {bad_sc, bad_pl}, {32'd1, 32'd3});

    // Overflow on the ninth event while the other lanes sit still.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      cyc(0, k, 0, 0);
      if (k == 8) chk("ovf_before", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    for (int k = 1; k <= 8; k++) cyc(0, 9, k, k);
    for (int k = 0; k < 3; k++)  cyc(0, 9, 8, 8);
    chk("ovf_cnt", match_count, 8);
    chk("ovf_mis", mismatch, 0);
    chk("ovf_idle", idle, 1);

    // Full FIFO: the ninth push lands on the edge its head pops.
    do_reset();
    for (int k = 1; k <= 8; k++) cyc(0, k, 0, 0);
    cyc(0, 8, 1, 1);
    cyc(0, 9, 2, 2);
    chk("full_pushpop_ovf", overflow, 0);
    for (int k = 3; k <= 9; k++) cyc(0, 9, k, k);
    for (int k = 0; k < 3; k++)  cyc(0, 9, 9, 9);
    chk("full_cnt", match_count, 9);
    chk("full_ovf", overflow, 0);
    chk("full_mis", mismatch, 0);

    // Reset with three events queued on lane 0.
    do_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 2, 0, 0);
    cyc(0, 3, 0, 0);
    chk("midrst_busy", idle, 0);
    cyc(1, 0, 0, 0);
    chk("midrst_idle", idle, 1);
    chk("midrst_cnt", match_count, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 2, 2);
    cyc(0, 0, 3, 3);
    cyc(0, 0, 3, 3);
    chk("midrst_nocmp", match_count, 0);
    chk("midrst_nomis", mismatch, 0);

    // Randomized lanes walking a shared sequence with skew, faults and resets.
    do_reset();
    for (int i = 0; i < 3; i++) begin idx[i] = 0; cur[i] = '0; end
    for (int n = 0; n < 3000; n++) begin
      int lo;
      bit r;
      lo = idx[0];
      for (int i = 1; i < 3; i++) if (idx[i] < lo) lo = idx[i];
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 2) == 0 && idx[i] - lo < 11) begin
          idx[i]++;
          cur[i] = ($urandom_range(0, 79) == 0) ? WIDTH'($urandom) : WIDTH'(idx[i]);
        end
      end
      r = ($urandom_range(0, 599) == 0);
      cyc(r, cur[0], cur[1], cur[2]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
